// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C command sequencer: expands one byte command into bit-controller commands and
// collects the received byte and the slave acknowledge.
module i2c_master_byte_ctrl (
  input  logic       wb_clk_i,
  input  logic       rst_i,
  input  logic       wb_rst_i,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  input  logic       i2c_al,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_rxd
);

  localparam logic [3:0] CmdIdle  = 4'b0000;
  localparam logic [3:0] CmdStart = 4'b0001;
  localparam logic [3:0] CmdStop  = 4'b0010;
  localparam logic [3:0] CmdWrite = 4'b0100;
  localparam logic [3:0] CmdRead  = 4'b1000;

  typedef enum logic [2:0] {StIdle, StStart, StWrite, StRead, StAck, StStop} state_e;

  state_e     state_q, state_d;
  logic [3:0] core_cmd_q, core_cmd_d;
  logic       core_txd_q, core_txd_d;
  logic       cmd_ack_q, cmd_ack_d;
  logic       ack_out_q, ack_out_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       go;

  // Blocking on cmd_ack stops a relaunch while the register block is still clearing cr.
  assign go = (read | write | stop) & ~cmd_ack_q;

  always_comb begin
    state_d    = state_q;
    core_cmd_d = core_cmd_q;
    core_txd_d = core_txd_q;
    cmd_ack_d  = 1'b0;
    ack_out_d  = ack_out_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;

    if (i2c_al) begin
      state_d    = StIdle;
      core_cmd_d = CmdIdle;
      core_txd_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (go) begin
            sr_d  = din;
            cnt_d = 3'd7;
            if (start) begin
              state_d    = StStart;
              core_cmd_d = CmdStart;
            end else if (read) begin
              state_d    = StRead;
              core_cmd_d = CmdRead;
            end else if (write) begin
              state_d    = StWrite;
              core_cmd_d = CmdWrite;
              core_txd_d = din[7];
            end else begin
              state_d    = StStop;
              core_cmd_d = CmdStop;
            end
          end
        end
        StStart: begin
          if (core_ack) begin
            if (read) begin
              state_d    = StRead;
              core_cmd_d = CmdRead;
            end else if (write) begin
              state_d    = StWrite;
              core_cmd_d = CmdWrite;
              core_txd_d = sr_q[7];
            end else begin
              state_d    = StStop;
              core_cmd_d = CmdStop;
            end
          end
        end
        StWrite, StRead: begin
          if (core_ack) begin
            sr_d = {sr_q[6:0], core_rxd};
            if (cnt_q != 3'd0) begin
              cnt_d      = cnt_q - 3'd1;
              core_txd_d = sr_q[6];
            end else begin
              state_d = StAck;
              // After a write the master samples the slave ACK; after a read it drives its own.
              if (state_q == StWrite) begin
                core_cmd_d = CmdRead;
              end else begin
                core_cmd_d = CmdWrite;
                core_txd_d = ack_in;
              end
            end
          end
        end
        StAck: begin
          if (core_ack) begin
            ack_out_d  = core_rxd;
            core_txd_d = 1'b1;
            if (stop) begin
              state_d    = StStop;
              core_cmd_d = CmdStop;
            end else begin
              state_d    = StIdle;
              core_cmd_d = CmdIdle;
              cmd_ack_d  = 1'b1;
            end
          end
        end
        StStop: begin
          if (core_ack) begin
            state_d    = StIdle;
            core_cmd_d = CmdIdle;
            cmd_ack_d  = 1'b1;
          end
        end
        default: begin
          state_d    = StIdle;
          core_cmd_d = CmdIdle;
        end
      endcase
    end

    if (wb_rst_i) begin
      state_d    = StIdle;
      core_cmd_d = CmdIdle;
      core_txd_d = 1'b0;
      cmd_ack_d  = 1'b0;
      ack_out_d  = 1'b0;
      sr_d       = 8'h00;
      cnt_d      = 3'd0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      core_cmd_q <= CmdIdle;
      core_txd_q <= 1'b0;
      cmd_ack_q  <= 1'b0;
      ack_out_q  <= 1'b0;
      sr_q       <= 8'h00;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      core_cmd_q <= core_cmd_d;
      core_txd_q <= core_txd_d;
      cmd_ack_q  <= cmd_ack_d;
      ack_out_q  <= ack_out_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign core_cmd = core_cmd_q;
  assign core_txd = core_txd_q;
  assign cmd_ack  = cmd_ack_q;
  assign ack_out  = ack_out_q;
  assign dout     = sr_q;

endmodule
